// File: rtl/apb_master_arb.sv
// apb_master_arb: two-port round-robin APB master with 2-bit slave decode.
// Optional APB_TIMEOUT_EN forces an error completion after TIMEOUT_CYCLES waits.
module apb_master_arb #(
  parameter int DEC_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        write0,
  input  logic        write1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  DECODE2BIT,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2;
  logic [1:0]  state_q, state_d, dec_q, dec_d;
  logic        last_q, last_d, gnt_q, gnt_d, pwrite_q, pwrite_d, psel_q, psel_d;
  logic        penable_q, penable_d, ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d, addr_sel;
  logic        elig0, elig1, pick1, done;
`ifdef APB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif
  assign elig0    = req0 & ~ack0_q;
  assign elig1    = req1 & ~ack1_q;
  assign pick1    = elig1 & (~elig0 | ~last_q);
  assign addr_sel = pick1 ? addr1 : addr0;
`ifdef APB_TIMEOUT_EN
  assign done = PREADY | (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign done = PREADY;
`endif
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    dec_d     = dec_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: if (elig0 | elig1) begin
        state_d  = SETUP;
        gnt_d    = pick1;
        last_d   = pick1;
        paddr_d  = addr_sel;
        pwrite_d = pick1 ? write1 : write0;
        pwdata_d = pick1 ? wdata1 : wdata0;
        dec_d    = addr_sel[DEC_LSB+1:DEC_LSB];
        psel_d   = 1'b1;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = 8'd0;
`endif
      end
      ACCESS: if (done) begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        ack0_d    = ~gnt_q;
        ack1_d    = gnt_q;
        // a timeout completes with PREADY low: zero data, error set
        rdata_d   = (PREADY & ~pwrite_q) ? PRDATA : 32'd0;
        err_d     = ~PREADY | PSLVERR;
      end else begin
`ifdef APB_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      dec_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      dec_q     <= dec_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign DECODE2BIT = dec_q;
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWDATA     = pwdata_q;
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed stimulus with a queue-based ack scoreboard.
module tb_apb_master_arb;
  localparam logic [31:0] K = 32'h5A5A_0000;
  logic        PCLK = 0, PRESETn = 0;
  logic        req0 = 0, req1 = 0, write0 = 0, write1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, rsp_err, PWRITE, PSEL, PENABLE;
  logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
  logic [1:0]  DECODE2BIT;
  logic        PREADY = 1, PSLVERR = 0;
  typedef struct packed {logic p; logic [31:0] d; logic e;} exp_t;
  exp_t q[$];
  int cmp = 0, bad = 0;
  assign PRDATA = PADDR ^ K;
  always #5 PCLK = ~PCLK;
  apb_master_arb #(.DEC_LSB(12), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .write0(write0), .write1(write1), .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .DECODE2BIT(DECODE2BIT), .PADDR(PADDR),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask
  task automatic wait_ack(input logic p, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (p ? ack1 : ack0) return;
    end
    chk("ack_timeout", 0, 1);
  endtask
  always @(negedge PCLK) if (PRESETn && (ack0 || ack1)) begin
    exp_t x;
    chk("one_ack", {31'd0, ack0 & ack1}, 0);
    if (q.size() == 0) chk("unexpected_ack", 1, 0);
    else begin
      x = q.pop_front();
      chk("ack_port", {31'd0, ack1}, {31'd0, x.p});
      chk("rsp_rdata", rsp_rdata, x.d);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, x.e});
    end
  end
  initial begin
    int lat, n0, n1;
    exp_t x;
    tick(); tick();
    chk("rst_psel", {31'd0, PSEL}, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_dec", {30'd0, DECODE2BIT}, 0);
    PRESETn = 1;
    // port 0 zero-wait write
    req0 = 1; addr0 = 32'h0000_2010; write0 = 1; wdata0 = 32'hA5A5_0001; PREADY = 1;
    x = '{1'b0, 32'd0, 1'b0}; q.push_back(x);
    tick();
    chk("w_psel", {31'd0, PSEL}, 1);
    chk("w_pen0", {31'd0, PENABLE}, 0);
    chk("w_paddr", PADDR, 32'h2010);
    chk("w_dec", {30'd0, DECODE2BIT}, 2);
    chk("w_pwrite", {31'd0, PWRITE}, 1);
    chk("w_pwdata", PWDATA, 32'hA5A5_0001);
    tick();
    chk("w_pen1", {31'd0, PENABLE}, 1);
    tick();
    chk("w_ack0", {31'd0, ack0}, 1);
    chk("w_psel_off", {31'd0, PSEL}, 0);
    req0 = 0;
    tick();
    chk("w_ack_once", {31'd0, ack0}, 0);
    chk("held_paddr", PADDR, 32'h2010);
    // port 1 read with two wait states
    req1 = 1; addr1 = 32'h3004; write1 = 0; PREADY = 0;
    x = '{1'b1, 32'h3004 ^ K, 1'b0}; q.push_back(x);
    tick(); tick();
    chk("r_pen", {31'd0, PENABLE}, 1);
    chk("r_dec", {30'd0, DECODE2BIT}, 3);
    tick();
    chk("r_wait1_addr", PADDR, 32'h3004);
    tick();
    chk("r_wait2_pen", {31'd0, PENABLE}, 1);
    chk("r_wait2_ack", {31'd0, ack1}, 0);
    PREADY = 1;
    tick();
    chk("r_ack1", {31'd0, ack1}, 1);
    req1 = 0;
    tick();
    // simultaneous requests after reset: grant 0,1,0,1
    PRESETn = 0; #1; PRESETn = 1;
    req0 = 1; addr0 = 32'h1000; write0 = 0;
    req1 = 1; addr1 = 32'h2000; write1 = 0;
    for (int i = 0; i < 4; i++) begin
      x = '{i[0], (i[0] ? 32'h2000 : 32'h1000) ^ K, 1'b0};
      q.push_back(x);
    end
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40 && (n0 + n1) < 4; i++) begin
      tick();
      if (ack0 || ack1) begin
        chk("rr_psel_gap", {31'd0, PSEL}, 0);
        if (ack0) n0++;
        if (ack1) n1++;
        if (n0 == 2) req0 = 0;
        if (n1 == 2) req1 = 0;
      end
    end
    chk("rr_count", n0 + n1, 4);
    tick();
    // reset during ACCESS drops the transfer
    req0 = 1; addr0 = 32'h0000_1234; write0 = 0; PREADY = 0;
    tick(); tick();
    chk("ra_pen", {31'd0, PENABLE}, 1);
    PRESETn = 0; #1;
    chk("ra_psel", {31'd0, PSEL}, 0);
    chk("ra_pen0", {31'd0, PENABLE}, 0);
    chk("ra_paddr", PADDR, 0);
    chk("ra_rdata", rsp_rdata, 0);
    chk("ra_ack", {31'd0, ack0}, 0);
    tick();
    PRESETn = 1; PREADY = 1;
    x = '{1'b0, 32'h1234 ^ K, 1'b0}; q.push_back(x);
    tick();
    chk("ra_setup_psel", {31'd0, PSEL}, 1);
    chk("ra_setup_pen", {31'd0, PENABLE}, 0);
    wait_ack(1'b0, lat);
    chk("ra_lat", lat, 2);
    req0 = 0;
    tick();
    // slave error then clean transfer
    PSLVERR = 1; req0 = 1; addr0 = 32'h0000_0040; write0 = 0;
    x = '{1'b0, 32'h40 ^ K, 1'b1}; q.push_back(x);
    wait_ack(1'b0, lat);
    chk("err_lat", lat, 3);
    req0 = 0; PSLVERR = 0;
    req1 = 1; addr1 = 32'h0000_1080; write1 = 1; wdata1 = 32'h1;
    x = '{1'b1, 32'd0, 1'b0}; q.push_back(x);
    wait_ack(1'b1, lat);
    req1 = 0;
    tick();
    // PREADY stuck low
    PREADY = 0; req0 = 1; addr0 = 32'h0000_0080; write0 = 0;
`ifdef APB_TIMEOUT_EN
    x = '{1'b0, 32'd0, 1'b1}; q.push_back(x);
    wait_ack(1'b0, lat);
    chk("to_lat", lat, 6);
`else
    n0 = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ack0) n0++;
    end
    chk("no_timeout_ack", n0, 0);
    chk("stuck_pen", {31'd0, PENABLE}, 1);
`endif
    req0 = 0; PRESETn = 0;
    tick();
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-port APB master and arbiter that drives the four-way APB slave multiplexer. It accepts single read or write requests from two requesters, for example the host bridge and the SPI DMA engine. It grants one requester at a time using round-robin arbitration, then runs the APB SETUP/ACCESS sequence, including `DECODE2BIT` slave selection. It returns read data and error status to the granted requester.

## Interface
Parameters:
- `DEC_LSB`, default 12: LSB of the 2-bit slave field. `DECODE2BIT = addr[DEC_LSB+1:DEC_LSB]`.
- `TIMEOUT_CYCLES`, default 255: maximum ACCESS cycles before forced termination. Used only with `APB_TIMEOUT_EN`. Range 1–255.

Ports:
- `PCLK` input 1: the only clock. All logic is on the rising edge.
- `PRESETn` input 1: asynchronous, active-low reset.
- `req0` / `req1` input 1: transfer request. Must be held high, with its fields stable, until the matching ack.
- `addr0` / `addr1` input 32: byte address.
- `write0` / `write1` input 1: 1 = write, 0 = read.
- `wdata0` / `wdata1` input 32: write data.
- `ack0` / `ack1` output 1: one-cycle completion pulse.
- `rsp_rdata` output 32: read data, valid while an ack is high. Zero for writes.
- `rsp_err` output 1: error status, valid while an ack is high.
- `DECODE2BIT` output 2: slave select to the mux.
- `PADDR` output 32, `PWRITE` output 1, `PSEL` output 1, `PENABLE` output 1, `PWDATA` output 32: APB request signals.
- `PRDATA` input 32, `PREADY` input 1, `PSLVERR` input 1: APB response from the mux.

## Operation
FSM states: IDLE, SETUP, ACCESS.

**IDLE**
- Eligible port = `reqN` high and `ackN` low. A port is never re-granted in its own ack cycle.
- One eligible port: grant it.
- Both eligible: grant the port not in `last_grant`.
- On a grant:
  - Register `PADDR`, `PWRITE`, `PWDATA` and `DECODE2BIT` from the granted port.
  - Set `PSEL`=1, `PENABLE`=0.
  - Update `last_grant` and go to SETUP.

**SETUP**
- Set `PENABLE`=1 and go to ACCESS unconditionally.

**ACCESS**
- Hold all APB outputs.
- When `PREADY`=1 at the edge:
  - Set `PSEL`=0, `PENABLE`=0.
  - Capture `rsp_rdata` (`PRDATA` for reads, 0 for writes) and `rsp_err` (= `PSLVERR`).
  - Pulse `ackN` for the granted port and return to IDLE.

**Held values**
- `PADDR`, `PWRITE`, `PWDATA` and `DECODE2BIT` keep their last values after a transfer.
- `rsp_rdata` and `rsp_err` keep their values until the next completion.

**Reset**
- `PRESETn` low, asynchronously, at any time including mid-transfer:
  - State goes to IDLE.
  - `last_grant`=1, so port 0 wins the first tie.
  - All outputs go to 0: `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `DECODE2BIT`, `ack0`, `ack1`, `rsp_rdata`, `rsp_err`.
  - An in-flight transfer is dropped without an ack. Requesters must reissue it.

**Boundary rules**
- A request is never lost. A losing port keeps `req` high and is served next.
- `PREADY` and `PSLVERR` are ignored outside ACCESS.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Zero-wait transfer, counting from the edge where `req` is sampled in IDLE:
  - Edge 0: SETUP (`PSEL`=1).
  - Edge 1: ACCESS (`PENABLE`=1).
  - Edge 2: `PREADY` is sampled. Ack is high from edge 2 to edge 3.
- Latency from `req` sampled to ack = 3 cycles, plus 1 cycle per wait state (`PREADY`=0 in ACCESS).
- Back-to-back throughput: one transfer per 4 cycles. The ack cycle is IDLE with no grant for the acked port. The other port may be granted in that same cycle, giving 3-cycle spacing.
- `PSEL` is low for at least one cycle between consecutive transfers.

## Configuration
Macro: `APB_TIMEOUT_EN`.

With the macro defined:
- An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with `PREADY`=0.
- When the count reaches `TIMEOUT_CYCLES` with `PREADY` still 0, the transfer terminates exactly as a completion, except:
  - `rsp_err`=1 and `rsp_rdata`=0.
  - `PSEL` and `PENABLE` are dropped.
- `PREADY`=1 in the same cycle takes priority, giving a normal completion.

Without the macro:
- There is no counter.
- ACCESS waits for `PREADY` indefinitely.

## Test plan
- Port 0 write, `addr0`=0x0000_2010, `wdata0`=0xA5A5_0001, `PREADY` tied 1:
  - `DECODE2BIT`=2, `PADDR`=0x2010, `PWRITE`=1.
  - `PSEL`/`PENABLE` follow the 0/1 sequence.
  - `ack0` pulses 3 cycles after `req`, with `rsp_err`=0.
- Port 1 read of 0x3004 with 2 wait states, `PRDATA`=0xDEAD_BEEF:
  - `ack1` arrives at cycle 5.
  - `rsp_rdata`=0xDEAD_BEEF; `PADDR`/`PENABLE` are held stable through the wait states.
- `req0` and `req1` asserted together after reset and held for 4 transfers:
  - Grant order is 0, 1, 0, 1.
  - `PSEL` drops for at least one cycle between transfers; no ack is duplicated.
- Slave returns `PSLVERR`=1 with `PREADY`=1 on a port 0 read:
  - `ack0` with `rsp_err`=1.
  - The next transfer has `rsp_err`=0.
- `PRESETn` pulsed low during ACCESS:
  - All outputs are 0 immediately, with no ack.
  - After release with `req0` still held, the transfer restarts from SETUP.
- With `APB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `PREADY` stuck 0:
  - Ack after 4 ACCESS cycles with `rsp_err`=1 and `rsp_rdata`=0.
  - Without the macro, no ack ever arrives.
